pe_share_sched: RTL and testbench

Round-robin issue scheduler that shares one fixed-latency, non-stallable pipelined FP processing element among `NUM_REQ` requesters. It accepts operand/op requests over valid/ready and drives the PE's operand/op inputs. It tags each issue, realigns tags with PE results, and returns results in issue order through a credit-protected response FIFO. It sits between per-column stream consumers and a shared PE (A/B/C/D class), one instance per shared PE.

---
 rtl/pe_sched_pkg.sv | 22 ++
 rtl/pe_sched_rsp_fifo.sv | 68 ++++++
 rtl/pe_share_sched.sv | 159 +++++++++++++++
 tb/tb_pe_share_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_sched_pkg.sv
// pe_share_sched shared types and constants.
// PE latency classes, operand width and the response FIFO entry layout.
package pe_sched_pkg;

    typedef logic [1:0] pe_op_t;

    localparam int DWIDTH_DOUBLE = 64;

    localparam int LAT_PE_A = 6;
    localparam int LAT_PE_B = 4;
    localparam int LAT_PE_C = 12;
    localparam int LAT_PE_D = 57;

    // Widest tag carried in a response entry (up to 256 requesters).
    localparam int TAG_MAX_W = 8;

    typedef struct packed {
        logic [TAG_MAX_W-1:0]     tag;
        logic [DWIDTH_DOUBLE-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/pe_sched_rsp_fifo.sv
// Response FIFO for pe_share_sched.
// Head is read from flops and forced to zero while empty.
module pe_sched_rsp_fifo
    import pe_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  rsp_entry_t wdata,
    input  logic       pop,
    output logic       valid,
    output rsp_entry_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    rsp_entry_t     mem [DEPTH];
    logic [AW-1:0]  wp;
    logic [AW-1:0]  rp;
    logic [CW-1:0]  cnt;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Entry storage; no reset needed since occupancy gates the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= nxt(wp);
            end
            if (pop) begin
                rp <= nxt(rp);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Credits upstream must make a write into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!push || pop || cnt != CW'(DEPTH))
            else $error("pe_sched_rsp_fifo overflow");
        end
    end

    assign valid = (cnt != '0);
    assign head  = valid ? mem[rp] : '0;

endmodule

// File: rtl/pe_share_sched.sv
// Round-robin issue scheduler sharing one pipelined FP PE.
// Optional perf counters: define PE_SCHED_PERF_EN.
module pe_share_sched
    import pe_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DWIDTH     = 64,
    parameter int LATENCY    = 6,
    parameter int RESP_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DWIDTH-1:0]   req_inp1,
    input  logic [NUM_REQ*DWIDTH-1:0]   req_inp2,
    input  logic [NUM_REQ*2-1:0]        req_op,
    output logic                        pe_valid_in,
    output logic [DWIDTH-1:0]           pe_inp1,
    output logic [DWIDTH-1:0]           pe_inp2,
    output logic [1:0]                  pe_op,
    input  logic [DWIDTH-1:0]           pe_out1,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_tag,
    output logic [DWIDTH-1:0]           rsp_data,
    output logic [CNT_W-1:0]            perf_issue_cnt,
    output logic [CNT_W-1:0]            perf_stall_cnt
);

    localparam int TW  = $clog2(NUM_REQ);
    localparam int CRW = $clog2(RESP_DEPTH + 1);

    logic [CRW-1:0] credit;
    logic [TW-1:0]  rr_ptr;
    logic [TW-1:0]  gnt_idx;
    logic           gnt_any;
    logic           issue;
    logic           pop;
    logic           fifo_valid;
    logic [LATENCY-1:0] tp_vld;
    logic [TW-1:0]  tp_tag [LATENCY];
    rsp_entry_t     wr_ent;
    rsp_entry_t     head;

    // First valid requester after the last grant, wrapping around.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!gnt_any && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = TW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign issue = gnt_any && (credit != '0) && !rst;

    // Accept strobe and PE operand mux for the winner.
    always_comb begin
        req_ready   = '0;
        pe_valid_in = 1'b0;
        pe_inp1     = '0;
        pe_inp2     = '0;
        pe_op       = '0;
        if (issue) begin
            req_ready[gnt_idx] = 1'b1;
            pe_valid_in        = 1'b1;
            pe_inp1            = req_inp1[gnt_idx*DWIDTH +: DWIDTH];
            pe_inp2            = req_inp2[gnt_idx*DWIDTH +: DWIDTH];
            pe_op              = req_op[gnt_idx*2 +: 2];
        end
    end

    // Round-robin pointer moves only when something is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= TW'(NUM_REQ - 1);
        end else if (issue) begin
            rr_ptr <= gnt_idx;
        end
    end

    // Tag pipeline tracking the PE; reset drops in-flight results.
    always_ff @(posedge clk) begin
        if (rst) begin
            tp_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tp_tag[i] <= '0;
            end
        end else begin
            tp_vld[0] <= issue;
            tp_tag[0] <= gnt_idx;
            for (int i = 1; i < LATENCY; i++) begin
                tp_vld[i] <= tp_vld[i-1];
                tp_tag[i] <= tp_tag[i-1];
            end
        end
    end

    assign wr_ent = '{
        tag:  TAG_MAX_W'(tp_tag[LATENCY-1]),
        data: DWIDTH_DOUBLE'(pe_out1)
    };

    pe_sched_rsp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tp_vld[LATENCY-1]),
        .wdata (wr_ent),
        .pop   (pop),
        .valid (fifo_valid),
        .head  (head)
    );

    assign pop       = fifo_valid && rsp_ready;
    assign rsp_valid = fifo_valid;
    assign rsp_tag   = head.tag[TW-1:0];
    assign rsp_data  = head.data[DWIDTH-1:0];

    logic unused_tag_hi;
    assign unused_tag_hi = ^head.tag[TAG_MAX_W-1:TW];

    // Credits: free FIFO slots minus ops still inside the PE.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= CRW'(RESP_DEPTH);
        end else if (issue && !pop) begin
            credit <= credit - CRW'(1);
        end else if (pop && !issue) begin
            credit <= credit + CRW'(1);
        end
    end

`ifdef PE_SCHED_PERF_EN
    // Issue and stall counters, free-running with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue) begin
                perf_issue_cnt <= perf_issue_cnt + CNT_W'(1);
            end
            if (|req_valid && credit == '0) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_share_sched.sv
// Self-checking bench for pe_share_sched.
// Random and directed traffic against a queue-based reference model.
module tb_pe_share_sched;

    localparam int NR  = 4;
    localparam int DW  = 64;
    localparam int LAT = 6;
    localparam int RD  = 8;
    localparam int CW  = 32;
    localparam int TW  = 2;

`ifdef PE_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_inp1;
    logic [NR*DW-1:0]  req_inp2;
    logic [NR*2-1:0]   req_op;
    logic              pe_valid_in;
    logic [DW-1:0]     pe_inp1;
    logic [DW-1:0]     pe_inp2;
    logic [1:0]        pe_op;
    logic [DW-1:0]     pe_out1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [TW-1:0]     rsp_tag;
    logic [DW-1:0]     rsp_data;
    logic [CW-1:0]     perf_issue_cnt;
    logic [CW-1:0]     perf_stall_cnt;

    pe_share_sched #(
        .NUM_REQ    (NR),
        .DWIDTH     (DW),
        .LATENCY    (LAT),
        .RESP_DEPTH (RD),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_inp1       (req_inp1),
        .req_inp2       (req_inp2),
        .req_op         (req_op),
        .pe_valid_in    (pe_valid_in),
        .pe_inp1        (pe_inp1),
        .pe_inp2        (pe_inp2),
        .pe_op          (pe_op),
        .pe_out1        (pe_out1),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_tag        (rsp_tag),
        .rsp_data       (rsp_data),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pe_fn(input logic [1:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        real x;
        real y;
        real r;
        x = $bitstoreal(a);
        y = $bitstoreal(b);
        case (op)
            2'd0:    r = x + y;
            2'd1:    r = x - y;
            2'd2:    r = x * y;
            default: r = (x > y) ? x : y;
        endcase
        return $realtobits(r);
    endfunction

    // Fixed-latency PE model; garbage out when nothing was issued.
    logic [63:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= pe_valid_in ? pe_fn(pe_op, pe_inp1, pe_inp2)
                               : {$urandom, $urandom};
        for (int k = 1; k < LAT; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end
    assign pe_out1 = pipe[LAT-1];

    typedef struct {
        int          tag;
        logic [63:0] data;
        int          rdy;
    } exp_t;

    exp_t        q[$];
    int          grant_log[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last = NR - 1;
    int          credit_m = RD;
    int          issue_m = 0;
    int          stall_m = 0;
    int          n_issue = 0;
    int          n_pop = 0;
    int          pop_cyc = -1;
    int          pop_tag = -1;
    logic [63:0] pop_data = '0;
    logic [63:0] d_in1 = '0;
    logic [63:0] d_in2 = '0;
    logic [1:0]  d_op = '0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // One clock: drive after the edge, check and advance model mid-cycle.
    task automatic step(input logic [NR-1:0] v, input logic rr,
                        input logic r, input bit rnd);
        int             g;
        logic [NR-1:0]  er;
        bit             stall;
        bit             ev;
        exp_t           e;
        @(posedge clk);
        #1;
        rst       = r;
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < NR; i++) begin
            if (rnd) begin
                req_inp1[i*DW +: DW] = $realtobits(real'($urandom_range(0, 20)));
                req_inp2[i*DW +: DW] = $realtobits(real'($urandom_range(0, 20)));
                req_op[i*2 +: 2]     = 2'($urandom_range(0, 3));
            end else begin
                req_inp1[i*DW +: DW] = d_in1;
                req_inp2[i*DW +: DW] = d_in2;
                req_op[i*2 +: 2]     = d_op;
            end
        end
        @(negedge clk);
        g = -1;
        if (!r && credit_m > 0) begin
            for (int k = 1; k <= NR; k++) begin
                if (g < 0 && v[(last + k) % NR]) g = (last + k) % NR;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("pe_valid_in", 64'(pe_valid_in), (g >= 0) ? 64'd1 : 64'd0);
        chk("pe_inp1", pe_inp1, (g >= 0) ? req_inp1[g*DW +: DW] : 64'd0);
        chk("pe_inp2", pe_inp2, (g >= 0) ? req_inp2[g*DW +: DW] : 64'd0);
        chk("pe_op", 64'(pe_op), (g >= 0) ? 64'(req_op[g*2 +: 2]) : 64'd0);
        chk("perf_issue", 64'(perf_issue_cnt), PERF ? 64'(issue_m) : 64'd0);
        chk("perf_stall", 64'(perf_stall_cnt), PERF ? 64'(stall_m) : 64'd0);
        stall = (|v) && (credit_m == 0);
        if (!r) begin
            ev = (q.size() > 0) && (q[0].rdy <= cyc);
            chk("rsp_valid", 64'(rsp_valid), ev ? 64'd1 : 64'd0);
            if (ev) begin
                chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
                chk("rsp_data", rsp_data, q[0].data);
                if (rr) begin
                    pop_cyc  = cyc;
                    pop_tag  = q[0].tag;
                    pop_data = q[0].data;
                    void'(q.pop_front());
                    credit_m++;
                    n_pop++;
                end
            end
            if (g >= 0) begin
                e.tag  = g;
                e.data = pe_fn(req_op[g*2 +: 2], req_inp1[g*DW +: DW],
                               req_inp2[g*DW +: DW]);
                e.rdy  = cyc + LAT + 1;
                q.push_back(e);
                last = g;
                credit_m--;
                issue_m++;
                n_issue++;
                grant_log.push_back(g);
            end
            if (stall) stall_m++;
        end else begin
            q.delete();
            credit_m = RD;
            last     = NR - 1;
            issue_m  = 0;
            stall_m  = 0;
        end
        cyc++;
    endtask

    task automatic run(input int n, input logic [NR-1:0] v,
                       input logic rr);
        for (int i = 0; i < n; i++) step(v, rr, 1'b0, 1'b1);
    endtask

    int t;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_inp1  = '0;
        req_inp2  = '0;
        req_op    = '0;

        for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b1, 1'b1);

        // Reset values.
        step('0, 1'b0, 1'b0, 1'b1);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);

        // Single request from requester 2: 1.0 + 2.0.
        d_in1 = $realtobits(1.0);
        d_in2 = $realtobits(2.0);
        d_op  = 2'd0;
        pop_cyc = -1;
        t = cyc;
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        run(10, '0, 1'b1);
        chk("single_lat", 64'(pop_cyc), 64'(t + LAT + 1));
        chk("single_tag", 64'(pop_tag), 64'd2);
        chk("single_data", pop_data, $realtobits(3.0));

        // Fairness with all requesters active.
        step('0, 1'b1, 1'b1, 1'b1);
        grant_log.delete();
        run(16, 4'b1111, 1'b1);
        chk("fair_n", 64'(grant_log.size()), 64'd16);
        for (int i = 0; i < grant_log.size(); i++) begin
            chk("fair_gnt", 64'(grant_log[i]), 64'(i % NR));
        end
        step('0, 1'b1, 1'b0, 1'b1);
        chk("fair_perf", 64'(perf_issue_cnt), PERF ? 64'd16 : 64'd0);
        run(10, '0, 1'b1);

        // Backpressure: credits run out after RESP_DEPTH issues.
        step('0, 1'b0, 1'b1, 1'b1);
        n_issue = 0;
        run(20, 4'b0001, 1'b0);
        chk("bp_issues", 64'(n_issue), 64'(RD));
        step(4'b0001, 1'b1, 1'b0, 1'b1);
        chk("bp_stall", 64'(perf_stall_cnt), PERF ? 64'd12 : 64'd0);
        n_issue = 0;
        run(5, 4'b0001, 1'b0);
        chk("bp_one", 64'(n_issue), 64'd1);

        // Issue and pop together while one credit remains.
        step('0, 1'b0, 1'b1, 1'b1);
        run(RD - 1, 4'b0001, 1'b0);
        run(LAT + 2, '0, 1'b0);
        n_issue = 0;
        run(1, 4'b0001, 1'b1);
        chk("c1_issue", 64'(n_issue), 64'd1);
        n_issue = 0;
        run(3, 4'b0001, 1'b0);
        chk("c1_after", 64'(n_issue), 64'd1);

        // Reset while three ops are in flight.
        step('0, 1'b1, 1'b1, 1'b1);
        run(3, 4'b0010, 1'b1);
        run(1, '0, 1'b1);
        step('0, 1'b1, 1'b1, 1'b1);
        n_pop = 0;
        run(12, '0, 1'b1);
        chk("rst_nopop", 64'(n_pop), 64'd0);
        grant_log.delete();
        n_issue = 0;
        run(10, 4'b1111, 1'b0);
        chk("rst_gnt0", grant_log.size() > 0 ? 64'(grant_log[0]) : 64'hffff,
            64'd0);
        chk("rst_credit", 64'(n_issue), 64'(RD));
        run(20, '0, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(NR'($urandom), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) == 0), 1'b1);
        end
        run(30, '0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
